multi_edge_debouncer: RTL and testbench

Parametrised N-channel debouncer/edge detector for the player buttons (fire, left, right, start).
- Each channel synchronises a raw input and tracks a debounced level.
- Emits a one-clock pulse on the configured edge, then locks out bounces for a programmable time.
- Optionally generates auto-repeat pulses while a button is held, so movement keys step the cannon.
- Sits between the board pins and the game-control FSM.

---
 rtl/multi_edge_debouncer_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 124 ++++++++++++
 rtl/multi_edge_debouncer.sv | 58 +++++
 tb/tb_multi_edge_debouncer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_debouncer_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
package multi_edge_debouncer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_LOCKOUT = 2'b01;
    localparam logic [1:0] ST_HELD    = 2'b10;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when an accepted transition to the given level should produce a pulse.
    function automatic logic edgeAllowed(input int mode, input logic rising);
        if (rising)
            return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        else
            return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, lockout/auto-repeat FSM and its tick counter.
module debounce_channel
    import multi_edge_debouncer_pkg::*;
#(
    parameter int LOCKOUT_US       = 1000,
    parameter int EDGE_MODE        = 0,
    parameter int REPEAT_EN        = 0,
    parameter int REPEAT_DELAY_US  = 300000,
    parameter int REPEAT_PERIOD_US = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_us_tick,
    input  logic i_in,
    output logic o_level,
    output logic o_pulse,
    output logic o_held
);

    localparam int CW = $clog2(maxOf3(LOCKOUT_US, REPEAT_DELAY_US, REPEAT_PERIOD_US)) + 1;
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCKOUT_US - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY_US - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD_US - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_first;
    logic          r_level;
    logic          r_pulse;
    logic          r_held;

    logic [CW-1:0] w_repLast;
    logic          w_changed;
    logic          w_lockDone;
    logic          w_repDone;
    logic          w_newEdgePulse;

    assign w_repLast      = r_first ? DELAY_LAST : PERIOD_LAST;
    assign w_changed      = (r_sync2 != r_level);
    assign w_lockDone     = i_us_tick && (r_cnt == LOCK_LAST);
    assign w_repDone      = i_us_tick && (r_cnt == w_repLast);
    assign w_newEdgePulse = edgeAllowed(EDGE_MODE, r_sync2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    // Repeat pulses fire regardless of edge mode; a release in HELD beats a same-cycle repeat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_changed) begin
                            r_level <= r_sync2;
                            r_pulse <= w_newEdgePulse;
                            r_cnt   <= '0;
                            r_state <= ST_LOCKOUT;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (w_lockDone) begin
                            r_cnt <= '0;
                            if (w_changed) begin
                                r_level <= r_sync2;
                                r_pulse <= w_newEdgePulse;
                            end else if (r_level && (REPEAT_EN != 0)) begin
                                r_first <= 1'b1;
                                r_held  <= 1'b1;
                                r_state <= ST_HELD;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else if (i_us_tick) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (!r_sync2) begin
                            r_level <= 1'b0;
                            r_pulse <= edgeAllowed(EDGE_MODE, 1'b0);
                            r_cnt   <= '0;
                            r_held  <= 1'b0;
                            r_state <= ST_LOCKOUT;
                        end else if (w_repDone) begin
                            r_pulse <= 1'b1;
                            r_cnt   <= '0;
                            r_first <= 1'b0;
                        end else if (i_us_tick) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_held  = r_held;

endmodule

// File: rtl/multi_edge_debouncer.sv
// N-channel button debouncer: shared microsecond prescaler feeding independent channels.
module multi_edge_debouncer
    import multi_edge_debouncer_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int CLK_PER_US       = 36,
    parameter int LOCKOUT_US       = 1000,
    parameter int EDGE_MODE        = 0,
    parameter int REPEAT_EN        = 0,
    parameter int REPEAT_DELAY_US  = 300000,
    parameter int REPEAT_PERIOD_US = 100000
) (
    input  logic            i_clk_36MHz,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_pulse,
    output logic [N_CH-1:0] o_held
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

    logic [PW-1:0] r_preCnt;
    logic          w_usTick;

    assign w_usTick = i_enable && (r_preCnt == PRE_LAST);

    // Frozen while disabled so lockout and repeat timing resume where they stopped.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            r_preCnt <= '0;
        end else if (i_enable) begin
            r_preCnt <= w_usTick ? '0 : r_preCnt + PW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : gen_ch
        debounce_channel #(
            .LOCKOUT_US       (LOCKOUT_US),
            .EDGE_MODE        (EDGE_MODE),
            .REPEAT_EN        (REPEAT_EN),
            .REPEAT_DELAY_US  (REPEAT_DELAY_US),
            .REPEAT_PERIOD_US (REPEAT_PERIOD_US)
        ) u_channel (
            .i_clk     (i_clk_36MHz),
            .i_reset   (i_reset),
            .i_enable  (i_enable),
            .i_us_tick (w_usTick),
            .i_in      (i_in[g]),
            .o_level   (o_level[g]),
            .o_pulse   (o_pulse[g]),
            .o_held    (o_held[g])
        );
    end

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Two debouncer configurations (rising-only, and both-edges with auto-repeat) on shared inputs, checked against a tick-timestamp model.
module tb_multi_edge_debouncer;

    localparam int N_CH = 4;
    localparam int CPU  = 4;
    localparam int LOCK = 10;
    localparam int RDLY = 20;
    localparam int RPER = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N_CH-1:0] in;
    logic [N_CH-1:0] levelA, pulseA, heldA;
    logic [N_CH-1:0] levelB, pulseB, heldB;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_edge_debouncer #(
        .N_CH(N_CH), .CLK_PER_US(CPU), .LOCKOUT_US(LOCK), .EDGE_MODE(0),
        .REPEAT_EN(0), .REPEAT_DELAY_US(RDLY), .REPEAT_PERIOD_US(RPER)
    ) dutA (
        .i_clk_36MHz(clk), .i_reset(rst), .i_enable(en), .i_in(in),
        .o_level(levelA), .o_pulse(pulseA), .o_held(heldA)
    );

    multi_edge_debouncer #(
        .N_CH(N_CH), .CLK_PER_US(CPU), .LOCKOUT_US(LOCK), .EDGE_MODE(2),
        .REPEAT_EN(1), .REPEAT_DELAY_US(RDLY), .REPEAT_PERIOD_US(RPER)
    ) dutB (
        .i_clk_36MHz(clk), .i_reset(rst), .i_enable(en), .i_in(in),
        .o_level(levelB), .o_pulse(pulseB), .o_held(heldB)
    );

    // Model: lockout and repeat deadlines are absolute microsecond-tick numbers.
    int              edgeModeOf[2] = '{0, 2};
    int              repEnOf[2]    = '{0, 1};
    logic [N_CH-1:0] mSync1, mSync2;
    int              enCycles, ticks;
    logic [N_CH-1:0] expLevel[2], expPulse[2], expHeld[2];
    bit   [N_CH-1:0] locked[2];
    int              expireAt[2][N_CH];
    int              nextRep[2][N_CH];
    int              pulseCnt[2][N_CH];

    function automatic bit wantEdge(input int mode, input bit rising);
        return rising ? (mode == 0 || mode == 2) : (mode == 1 || mode == 2);
    endfunction

    task automatic acceptEdge(input int d, input int c, input bit v);
        expLevel[d][c] = v;
        expPulse[d][c] = wantEdge(edgeModeOf[d], v);
        locked[d][c]   = 1'b1;
        expireAt[d][c] = ticks + LOCK;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs currently driven.
    task automatic modelStep();
        logic [N_CH-1:0] s;
        bit tick;
        if (rst) begin
            mSync1 = '0; mSync2 = '0; enCycles = 0; ticks = 0;
            for (int d = 0; d < 2; d++) begin
                expLevel[d] = '0; expPulse[d] = '0; expHeld[d] = '0; locked[d] = '0;
            end
            return;
        end
        s = mSync2;
        mSync2 = mSync1;
        mSync1 = in;
        for (int d = 0; d < 2; d++) expPulse[d] = '0;
        if (!en) return;
        tick = ((enCycles % CPU) == CPU - 1);
        enCycles++;
        if (tick) ticks++;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (expHeld[d][c]) begin
                    if (!s[c]) begin
                        expHeld[d][c] = 1'b0;
                        acceptEdge(d, c, 1'b0);
                    end else if (tick && ticks == nextRep[d][c]) begin
                        expPulse[d][c] = 1'b1;
                        nextRep[d][c]  = ticks + RPER;
                    end
                end else if (locked[d][c]) begin
                    if (tick && ticks == expireAt[d][c]) begin
                        if (s[c] != expLevel[d][c]) begin
                            acceptEdge(d, c, s[c]);
                        end else if (expLevel[d][c] && repEnOf[d] != 0) begin
                            locked[d][c]  = 1'b0;
                            expHeld[d][c] = 1'b1;
                            nextRep[d][c] = ticks + RDLY;
                        end else begin
                            locked[d][c] = 1'b0;
                        end
                    end
                end else if (s[c] != expLevel[d][c]) begin
                    acceptEdge(d, c, s[c]);
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] newIn, input logic newEn, input logic newRst);
        in  = newIn;
        en  = newEn;
        rst = newRst;
    endtask

    task automatic clearPulseCounts();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N_CH; c++) pulseCnt[d][c] = 0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            modelStep();
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                pulseCnt[0][c] += int'(pulseA[c] === 1'b1);
                pulseCnt[1][c] += int'(pulseB[c] === 1'b1);
            end
            checkOutput("levelA", 32'(levelA), 32'(expLevel[0]));
            checkOutput("pulseA", 32'(pulseA), 32'(expPulse[0]));
            checkOutput("heldA",  32'(heldA),  32'(expHeld[0]));
            checkOutput("levelB", 32'(levelB), 32'(expLevel[1]));
            checkOutput("pulseB", 32'(pulseB), 32'(expPulse[1]));
            checkOutput("heldB",  32'(heldB),  32'(expHeld[1]));
        end
    endtask

    initial begin
        logic [N_CH-1:0] cur;
        int offLeft;
        $display("[TB] starting multi_edge_debouncer bench");
        clearPulseCounts();

        applyStimulus('0, 1'b1, 1'b1);
        runCycles(2);
        checkOutput("reset_outputs", 32'({levelA, pulseA, heldA, levelB, pulseB, heldB}), 32'd0);

        // Clean press on channel 0: pulse appears after the third edge only.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        runCycles(2);
        checkOutput("press_no_early_pulse", 32'(pulseA[0]), 32'd0);
        runCycles(1);
        checkOutput("press_pulse", 32'(pulseA), 32'b0001);
        checkOutput("press_level", 32'(levelA), 32'b0001);
        runCycles(1);
        checkOutput("press_pulse_one_cycle", 32'(pulseA[0]), 32'd0);
        runCycles(50);

        // Bouncing press on channel 1.
        clearPulseCounts();
        cur = 4'b0011;
        applyStimulus(cur, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runCycles(3);
            cur[1] = ~cur[1];
            applyStimulus(cur, 1'b1, 1'b0);
        end
        runCycles(3);
        checkOutput("bounce_level_in_lockout", 32'(levelA[1]), 32'd1);
        runCycles(40);
        checkOutput("bounce_one_pulse", 32'(pulseCnt[0][1]), 32'd1);
        checkOutput("bounce_settled_level", 32'(levelA[1]), 32'd1);

        // Release during lockout on channel 3.
        clearPulseCounts();
        cur[3] = 1'b1;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(8);
        cur[3] = 1'b0;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(60);
        checkOutput("release_both_pulses", 32'(pulseCnt[1][3]), 32'd2);
        checkOutput("release_rise_only", 32'(pulseCnt[0][3]), 32'd1);
        checkOutput("release_level", 32'(levelB[3]), 32'd0);

        // Hold channel 2: lockout, repeat at 80 cycles then every 32.
        clearPulseCounts();
        cur[2] = 1'b1;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(240);
        checkOutput("hold_pulses", 32'(pulseCnt[1][2]), 32'd5);
        checkOutput("hold_heldB", 32'(heldB[2]), 32'd1);
        checkOutput("hold_no_repeat_A", 32'(pulseCnt[0][2]), 32'd1);
        clearPulseCounts();
        cur[2] = 1'b0;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(60);
        checkOutput("unhold_heldB", 32'(heldB[2]), 32'd0);
        checkOutput("unhold_single_fall", 32'(pulseCnt[1][2]), 32'd1);

        // Enable dropped for 100 cycles in the middle of a lockout.
        clearPulseCounts();
        cur[0] = 1'b0;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(12);
        applyStimulus(cur, 1'b0, 1'b0);
        runCycles(100);
        checkOutput("disabled_no_pulse", 32'(pulseCnt[1][0]), 32'd1);
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(60);

        // Reset while channel 2 of the repeat instance is held.
        cur[2] = 1'b1;
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(130);
        checkOutput("pre_reset_held", 32'(heldB[2]), 32'd1);
        applyStimulus(cur, 1'b1, 1'b1);
        runCycles(1);
        checkOutput("reset_held_cleared", 32'({levelB[2], pulseB[2], heldB[2]}), 32'd0);
        applyStimulus(cur, 1'b1, 1'b0);
        runCycles(2);
        checkOutput("after_reset_no_early", 32'(pulseB[2]), 32'd0);
        runCycles(1);
        checkOutput("after_reset_pulse", 32'(pulseB[2]), 32'd1);

        // Random traffic with occasional enable drops and resets.
        offLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(15) == 0) cur[c] = ~cur[c];
            if (offLeft > 0) offLeft--;
            else if ($urandom_range(63) == 0) offLeft = $urandom_range(20, 1);
            applyStimulus(cur, (offLeft == 0), ($urandom_range(999) == 0));
            runCycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
